// File: rtl/sdx_kernel_addwm_example_wm_ctrl_if.sv
// Control/status bundle between the AXI-Lite control slave, the run sequencer and the data movers.
// Latency: none, wires only.
// Backpressure: none; every beat/done signal is a pre-qualified single-cycle pulse.
//
// Ports grouped here:
//   ap_start/ap_idle/ap_done/ap_ready    run handshake with the control-register block
//   *_xfer_size_in_bytes, ctrl_timeout_cycles  run parameters, sampled at start
//   wm_rd_start/wm_rd_done/wm_beat        watermark reader
//   im_start/im_beat/out_beat/write_done  image read/write masters
//   wm_mismatch/im_mismatch/timeout       sticky per-run status
// slave  = sequencer side, master = control/data-mover side.
interface sdx_kernel_addwm_example_wm_ctrl_if #(
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_TIMEOUT_WIDTH   = 24
);
  logic                         ap_start;
  logic                         ap_idle;
  logic                         ap_done;
  logic                         ap_ready;
  logic [C_XFER_SIZE_WIDTH-1:0] wm_xfer_size_in_bytes;
  logic [C_XFER_SIZE_WIDTH-1:0] im_xfer_size_in_bytes;
  logic [C_TIMEOUT_WIDTH-1:0]   ctrl_timeout_cycles;
  logic                         wm_rd_start;
  logic                         wm_rd_done;
  logic                         wm_beat;
  logic                         im_start;
  logic                         im_beat;
  logic                         out_beat;
  logic                         write_done;
  logic                         wm_mismatch;
  logic                         im_mismatch;
  logic                         timeout;

  modport slave (
    input  ap_start, wm_xfer_size_in_bytes, im_xfer_size_in_bytes, ctrl_timeout_cycles,
           wm_rd_done, wm_beat, im_beat, out_beat, write_done,
    output ap_idle, ap_done, ap_ready, wm_rd_start, im_start,
           wm_mismatch, im_mismatch, timeout
  );

  modport master (
    output ap_start, wm_xfer_size_in_bytes, im_xfer_size_in_bytes, ctrl_timeout_cycles,
           wm_rd_done, wm_beat, im_beat, out_beat, write_done,
    input  ap_idle, ap_done, ap_ready, wm_rd_start, im_start,
           wm_mismatch, im_mismatch, timeout
  );
endinterface

// File: rtl/sdx_kernel_addwm_example_wm_ctrl.sv
// Two-phase run sequencer: watermark fetch, then image read/embed/write; beat audit and stall watchdog.
// Latency: ap_start -> wm_rd_start 1 cycle; done pulse -> next phase 2 cycles; zero-size run -> ap_done 1 cycle.
// Backpressure: none; a stalled phase is ended by the watchdog (if enabled) with the timeout flag set.
//
// Ports:
//   aclk    sole clock, rising edge
//   areset  synchronous active-high reset; aborts any run without ap_done
//   ctl     control/status bundle (slave view), see the interface file
module sdx_kernel_addwm_example_wm_ctrl #(
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_TIMEOUT_WIDTH    = 24
) (
  input  logic                              aclk,
  input  logic                              areset,
  sdx_kernel_addwm_example_wm_ctrl_if.slave ctl
);
  localparam int          XW          = C_XFER_SIZE_WIDTH;
  localparam int          TW          = C_TIMEOUT_WIDTH;
  localparam int          LP_DW_BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int          LP_DW_SHIFT = $clog2(LP_DW_BYTES);
  localparam logic [XW:0] LP_ROUND    = (XW+1)'(LP_DW_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WM_START,
    S_WM_WAIT,
    S_IM_START,
    S_IM_WAIT,
    S_DONE
  } state_t;

  // Run parameters captured at start; expected counts carry one extra bit so that
  // an all-ones byte count still rounds up without wrapping.
  typedef struct packed {
    logic [XW:0]   wm_exp;
    logic [XW:0]   im_exp;
    logic [TW-1:0] tmo;
  } cfg_t;

  typedef struct packed {
    logic wm_mismatch;
    logic im_mismatch;
    logic timeout;
  } flags_t;

  state_t        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  flags_t        flags_q, flags_d;
  logic          wm_done_q, wm_done_d;
  logic          wr_done_q, wr_done_d;
  logic [XW-1:0] wm_cnt_q, wm_cnt_d;
  logic [XW-1:0] im_cnt_q, im_cnt_d;
  logic [XW-1:0] out_cnt_q, out_cnt_d;
  logic [TW-1:0] wd_q, wd_d;

  logic          busy;
  logic          in_wait;
  logic          any_beat;
  logic          wd_fire;
  logic [XW:0]   wm_exp_new;
  logic [XW:0]   im_exp_new;

  function automatic logic [XW-1:0] sat_inc(input logic [XW-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign busy     = (state_q != S_IDLE);
  assign in_wait  = (state_q == S_WM_WAIT) || (state_q == S_IM_WAIT);
  assign any_beat = ctl.wm_beat || ctl.im_beat || ctl.out_beat;
  // Compared against the registered count, so the limit-th idle cycle after entry
  // (or after the last beat) ends the phase on the following edge.
  assign wd_fire  = in_wait && (cfg_q.tmo != '0) && (wd_q == cfg_q.tmo);

  assign wm_exp_new = ({1'b0, ctl.wm_xfer_size_in_bytes} + LP_ROUND) >> LP_DW_SHIFT;
  assign im_exp_new = ({1'b0, ctl.im_xfer_size_in_bytes} + LP_ROUND) >> LP_DW_SHIFT;

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    flags_d   = flags_q;
    wm_done_d = wm_done_q;
    wr_done_d = wr_done_q;
    wm_cnt_d  = wm_cnt_q;
    im_cnt_d  = im_cnt_q;
    out_cnt_d = out_cnt_q;
    wd_d      = '0;

    // Done pulses are remembered from the start pulse onwards, so a mover that
    // finishes before its phase is waited on is still honoured.
    if (busy) begin
      wm_done_d = wm_done_q | ctl.wm_rd_done;
      wr_done_d = wr_done_q | ctl.write_done;
      wm_cnt_d  = sat_inc(wm_cnt_q, ctl.wm_beat);
      im_cnt_d  = sat_inc(im_cnt_q, ctl.im_beat);
      out_cnt_d = sat_inc(out_cnt_q, ctl.out_beat);
    end

    // Outside the wait states the watchdog sits at zero, which also clears it on entry.
    if (in_wait && !any_beat) begin
      wd_d = wd_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (ctl.ap_start) begin
          cfg_d.wm_exp = wm_exp_new;
          cfg_d.im_exp = im_exp_new;
          cfg_d.tmo    = ctl.ctrl_timeout_cycles;
          flags_d      = '0;
          wm_done_d    = 1'b0;
          wr_done_d    = 1'b0;
          wm_cnt_d     = '0;
          im_cnt_d     = '0;
          out_cnt_d    = '0;
          if (ctl.wm_xfer_size_in_bytes != '0) begin
            state_d = S_WM_START;
          end else if (ctl.im_xfer_size_in_bytes != '0) begin
            state_d = S_IM_START;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WM_START: state_d = S_WM_WAIT;
      S_WM_WAIT: begin
        // Timeout takes priority over a coincident done.
        if (wd_fire) begin
          flags_d.timeout = 1'b1;
          state_d         = S_DONE;
        end else if (wm_done_q) begin
          state_d = (cfg_q.im_exp != '0) ? S_IM_START : S_DONE;
        end
      end
      S_IM_START: state_d = S_IM_WAIT;
      S_IM_WAIT: begin
        if (wd_fire) begin
          flags_d.timeout = 1'b1;
          state_d         = S_DONE;
        end else if (wr_done_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Registered counts exclude beats arriving in this cycle.
        flags_d.wm_mismatch = ({1'b0, wm_cnt_q} != cfg_q.wm_exp);
        flags_d.im_mismatch = ({1'b0, im_cnt_q} != cfg_q.im_exp) ||
                              ({1'b0, out_cnt_q} != cfg_q.im_exp);
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      flags_q   <= '0;
      wm_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      wm_cnt_q  <= '0;
      im_cnt_q  <= '0;
      out_cnt_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      flags_q   <= flags_d;
      wm_done_q <= wm_done_d;
      wr_done_q <= wr_done_d;
      wm_cnt_q  <= wm_cnt_d;
      im_cnt_q  <= im_cnt_d;
      out_cnt_q <= out_cnt_d;
      wd_q      <= wd_d;
    end
  end

  assign ctl.ap_idle     = (state_q == S_IDLE);
  assign ctl.ap_done     = (state_q == S_DONE);
  assign ctl.ap_ready    = (state_q == S_DONE);
  assign ctl.wm_rd_start = (state_q == S_WM_START);
  assign ctl.im_start    = (state_q == S_IM_START);
  assign ctl.wm_mismatch = flags_q.wm_mismatch;
  assign ctl.im_mismatch = flags_q.im_mismatch;
  assign ctl.timeout     = flags_q.timeout;
endmodule

// File: tb/tb_sdx_kernel_addwm_example_wm_ctrl.sv
module tb_sdx_kernel_addwm_example_wm_ctrl;
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  sdx_kernel_addwm_example_wm_ctrl_if #(.C_XFER_SIZE_WIDTH(32), .C_TIMEOUT_WIDTH(24)) ctl ();

  sdx_kernel_addwm_example_wm_ctrl #(
    .C_XFER_SIZE_WIDTH (32),
    .C_M_AXI_DATA_WIDTH(512),
    .C_TIMEOUT_WIDTH   (24)
  ) dut (
    .aclk  (aclk),
    .areset(areset),
    .ctl   (ctl.slave)
  );

  int total = 0;
  int bad   = 0;

  // Edge index: after the k-th rising edge cyc == k.
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Pulse monitor: cumulative counts and the edge after which each pulse was seen.
  int n_wmst = 0, n_imst = 0, n_done = 0, n_rdy_bad = 0;
  int e_wmst = 0, e_imst = 0, e_done = 0;
  always @(negedge aclk) begin
    if (ctl.wm_rd_start) begin n_wmst <= n_wmst + 1; e_wmst <= cyc; end
    if (ctl.im_start)    begin n_imst <= n_imst + 1; e_imst <= cyc; end
    if (ctl.ap_done)     begin n_done <= n_done + 1; e_done <= cyc; end
    if (ctl.ap_ready !== ctl.ap_done) n_rdy_bad <= n_rdy_bad + 1;
  end

  int b_wmst, b_imst, b_done, b_rdy;
  int e_start, e_wmdone, e_wrdone;
  logic obs_start_idle, obs_idle_after, got_done;
  logic [2:0] obs_start_flags;

  // Reference: one beat per started 64-byte word.
  function automatic int exp_beats(input logic [31:0] bytes);
    return int'((longint'(bytes) + 64'd63) / 64'd64);
  endfunction

  // Drives one run as the control block and data movers would; called #1 after an edge with DUT idle.
  task automatic run(input logic [31:0] wmb, input logic [31:0] imb, input logic [23:0] tmo,
                     input int nwm, input int nim, input int nout, input int wm_dly,
                     input bit give_wm_done, input bit early_wr);
    int left, ileft, oleft, i;
    bit dsent, wsent, seen_im;
    b_wmst = n_wmst; b_imst = n_imst; b_done = n_done; b_rdy = n_rdy_bad;
    got_done = 1'b0; obs_idle_after = 1'b0; seen_im = 1'b0;
    ctl.wm_xfer_size_in_bytes = wmb;
    ctl.im_xfer_size_in_bytes = imb;
    ctl.ctrl_timeout_cycles   = tmo;
    ctl.ap_start = 1'b1; e_start = cyc + 1;
    @(posedge aclk); #1;
    ctl.ap_start = 1'b0;
    obs_start_idle  = ctl.ap_idle;
    obs_start_flags = {ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout};
    if (wmb != 0) begin
      left = nwm; dsent = !give_wm_done; wsent = !early_wr; i = 0;
      while ((left > 0 || !dsent || !wsent) && i < 300) begin
        seen_im = seen_im || ctl.im_start;
        ctl.wm_beat = (left > 0) && ($urandom_range(3) != 0);
        if (ctl.wm_beat) left--;
        ctl.wm_rd_done = !dsent && ((wm_dly >= 0) ? (i >= wm_dly) : (left == 0));
        if (ctl.wm_rd_done) begin dsent = 1'b1; e_wmdone = cyc + 1; end
        ctl.write_done = !wsent && (i == 1);
        if (ctl.write_done) wsent = 1'b1;
        i++;
        @(posedge aclk); #1;
      end
      ctl.wm_beat = 1'b0; ctl.wm_rd_done = 1'b0; ctl.write_done = 1'b0;
    end
    for (int k = 0; k < 40 && !(ctl.im_start || ctl.ap_done || seen_im); k++) begin
      @(posedge aclk); #1;
      seen_im = seen_im || ctl.im_start;
    end
    if (ctl.im_start || seen_im) begin
      ileft = nim; oleft = nout; wsent = early_wr; i = 0;
      while ((ileft > 0 || oleft > 0 || !wsent) && i < 300) begin
        ctl.im_beat = (ileft > 0) && ($urandom_range(3) != 0);
        if (ctl.im_beat) ileft--;
        ctl.out_beat = (oleft > 0) && ($urandom_range(3) != 0);
        if (ctl.out_beat) oleft--;
        ctl.write_done = !wsent && (ileft == 0) && (oleft == 0);
        if (ctl.write_done) begin wsent = 1'b1; e_wrdone = cyc + 1; end
        i++;
        @(posedge aclk); #1;
      end
      ctl.im_beat = 1'b0; ctl.out_beat = 1'b0; ctl.write_done = 1'b0;
    end
    for (int k = 0; k < 40 && !ctl.ap_done; k++) begin
      @(posedge aclk); #1;
    end
    got_done = ctl.ap_done;
    @(posedge aclk); #1;
    obs_idle_after = ctl.ap_idle;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    total++; if (ctl.ap_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", ctl.ap_idle); end
    total++; if ({ctl.ap_done, ctl.ap_ready, ctl.wm_rd_start, ctl.im_start} !== 4'b0000) begin
      bad++; $display("FAIL reset_pulses got=%b want=0000", {ctl.ap_done, ctl.ap_ready, ctl.wm_rd_start, ctl.im_start}); end
    total++; if ({ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout}); end
    areset = 1'b0;
    @(posedge aclk); #1;
    total++; if (ctl.ap_idle !== 1'b1) begin bad++; $display("FAIL reset_stay_idle got=%b want=1", ctl.ap_idle); end
  endtask

  task automatic test_basic();
    run(32'd1024, 32'd4096, 24'd0, 16, 64, 64, 5, 1'b1, 1'b0);
    total++; if (n_wmst - b_wmst !== 1) begin bad++; $display("FAIL basic_wm_start_cnt got=%0d want=1", n_wmst - b_wmst); end
    total++; if (n_imst - b_imst !== 1) begin bad++; $display("FAIL basic_im_start_cnt got=%0d want=1", n_imst - b_imst); end
    total++; if (obs_start_idle !== 1'b0) begin bad++; $display("FAIL basic_idle_after_start got=%b want=0", obs_start_idle); end
    total++; if (e_wmst - e_start !== 0) begin bad++; $display("FAIL basic_wm_start_lat got=%0d want=0", e_wmst - e_start); end
    total++; if (e_imst - e_wmdone !== 1) begin bad++; $display("FAIL basic_im_start_lat got=%0d want=1", e_imst - e_wmdone); end
    total++; if (n_done - b_done !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d want=1", n_done - b_done); end
    total++; if (e_done - e_wrdone !== 1) begin bad++; $display("FAIL basic_done_lat got=%0d want=1", e_done - e_wrdone); end
    total++; if (n_rdy_bad - b_rdy !== 0) begin bad++; $display("FAIL basic_ready_eq_done got=%0d want=0", n_rdy_bad - b_rdy); end
    total++; if (obs_idle_after !== 1'b1) begin bad++; $display("FAIL basic_idle_after_done got=%b want=1", obs_idle_after); end
    total++; if ({ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout} !== {16 != exp_beats(1024), 64 != exp_beats(4096), 1'b0}) begin
      bad++; $display("FAIL basic_flags got=%b want=000", {ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout}); end
  endtask

  task automatic test_zero();
    run(32'd0, 32'd0, 24'd0, 0, 0, 0, -1, 1'b1, 1'b0);
    total++; if (n_done - b_done !== 1) begin bad++; $display("FAIL zero_done_cnt got=%0d want=1", n_done - b_done); end
    total++; if (e_done - e_start !== 0) begin bad++; $display("FAIL zero_done_lat got=%0d want=0", e_done - e_start); end
    total++; if ((n_wmst - b_wmst) + (n_imst - b_imst) !== 0) begin
      bad++; $display("FAIL zero_no_starts got=%0d want=0", (n_wmst - b_wmst) + (n_imst - b_imst)); end
  endtask

  task automatic test_im_mismatch();
    run(32'd0, 32'd100, 24'd0, 0, 1, 2, -1, 1'b1, 1'b0);
    total++; if (ctl.im_mismatch !== 1'b1) begin bad++; $display("FAIL short_im_mismatch got=%b want=1", ctl.im_mismatch); end
    total++; if (ctl.wm_mismatch !== 1'b0) begin bad++; $display("FAIL short_wm_mismatch got=%b want=0", ctl.wm_mismatch); end
    run(32'd0, 32'd100, 24'd0, 0, exp_beats(100), exp_beats(100), -1, 1'b1, 1'b0);
    total++; if (obs_start_flags !== 3'b000) begin bad++; $display("FAIL short_flags_clear_on_start got=%b want=000", obs_start_flags); end
    total++; if (ctl.im_mismatch !== 1'b0) begin bad++; $display("FAIL exact_im_mismatch got=%b want=0", ctl.im_mismatch); end
  endtask

  task automatic test_timeout();
    run(32'd256, 32'd256, 24'd10, 0, 0, 0, -1, 1'b0, 1'b0);
    total++; if (ctl.timeout !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b want=1", ctl.timeout); end
    total++; if (n_done - b_done !== 1) begin bad++; $display("FAIL tmo_done_cnt got=%0d want=1", n_done - b_done); end
    // wm_rd_start, one cycle to enter WM_WAIT, then 11 cycles in WM_WAIT.
    total++; if (e_done - e_wmst !== 12) begin bad++; $display("FAIL tmo_done_lat got=%0d want=12", e_done - e_wmst); end
    total++; if (n_imst - b_imst !== 0) begin bad++; $display("FAIL tmo_no_im_start got=%0d want=0", n_imst - b_imst); end
    total++; if ({ctl.wm_mismatch, ctl.im_mismatch} !== {exp_beats(256) != 0, exp_beats(256) != 0}) begin
      bad++; $display("FAIL tmo_mismatch_flags got=%b want=11", {ctl.wm_mismatch, ctl.im_mismatch}); end
  endtask

  task automatic test_early_write();
    run(32'd128, 32'd128, 24'd0, exp_beats(128), 0, 0, 4, 1'b1, 1'b1);
    total++; if (obs_start_flags !== 3'b000) begin bad++; $display("FAIL early_flags_clear_on_start got=%b want=000", obs_start_flags); end
    total++; if (got_done !== 1'b1) begin bad++; $display("FAIL early_run_completes got=%b want=1", got_done); end
    total++; if (e_done - e_imst !== 2) begin bad++; $display("FAIL early_no_second_wait got=%0d want=2", e_done - e_imst); end
    total++; if ({ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout} !== {1'b0, exp_beats(128) != 0, 1'b0}) begin
      bad++; $display("FAIL early_flags got=%b want=010", {ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout}); end
  endtask

  task automatic test_reset_mid_run();
    int bd;
    bd = n_done;
    ctl.wm_xfer_size_in_bytes = 32'd0;
    ctl.im_xfer_size_in_bytes = 32'd256;
    ctl.ctrl_timeout_cycles   = 24'd0;
    ctl.ap_start = 1'b1;
    @(posedge aclk); #1;
    ctl.ap_start = 1'b0;
    total++; if (ctl.im_start !== 1'b1) begin bad++; $display("FAIL midrst_im_start got=%b want=1", ctl.im_start); end
    @(posedge aclk); #1;
    ctl.im_beat = 1'b1;
    @(posedge aclk); #1;
    ctl.im_beat = 1'b0;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    total++; if (ctl.ap_idle !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b want=1", ctl.ap_idle); end
    total++; if ({ctl.ap_done, ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout} !== 4'b0000) begin
      bad++; $display("FAIL midrst_outputs got=%b want=0000", {ctl.ap_done, ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout}); end
    repeat (6) @(posedge aclk);
    #1;
    total++; if (n_done - bd !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", n_done - bd); end
    run(32'd0, 32'd256, 24'd0, 0, exp_beats(256), exp_beats(256), -1, 1'b1, 1'b0);
    total++; if (n_done - b_done !== 1) begin bad++; $display("FAIL midrst_fresh_done got=%0d want=1", n_done - b_done); end
    total++; if ({ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout} !== 3'b000) begin
      bad++; $display("FAIL midrst_fresh_flags got=%b want=000", {ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout}); end
  endtask

  task automatic test_back_to_back();
    int bd;
    bd = n_done;
    ctl.wm_xfer_size_in_bytes = 32'd0;
    ctl.im_xfer_size_in_bytes = 32'd0;
    ctl.ap_start = 1'b1;
    repeat (10) @(posedge aclk);
    #1;
    ctl.ap_start = 1'b0;
    @(posedge aclk); #1;
    // Each zero-size run needs one accept cycle in IDLE plus one DONE cycle.
    total++; if (n_done - bd !== 10 / 2) begin bad++; $display("FAIL b2b_done_cnt got=%0d want=5", n_done - bd); end
    total++; if (ctl.ap_idle !== 1'b1) begin bad++; $display("FAIL b2b_idle_end got=%b want=1", ctl.ap_idle); end
  endtask

  task automatic test_random();
    logic [31:0] wmb, imb;
    int ew, ei, nwm, nim, nout;
    bit xw, xi;
    for (int it = 0; it < 8; it++) begin
      wmb = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(600, 1));
      imb = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(600, 1));
      ew = exp_beats(wmb);
      ei = exp_beats(imb);
      nwm  = (wmb == 0) ? 0 : ew + int'($urandom_range(2)) - 1;
      nim  = (imb == 0) ? 0 : ei + int'($urandom_range(2)) - 1;
      nout = (imb == 0) ? 0 : ei + int'($urandom_range(2)) - 1;
      xw = (nwm != ew);
      xi = (nim != ei) || (nout != ei);
      run(wmb, imb, 24'd50, nwm, nim, nout, -1, 1'b1, 1'b0);
      total++; if (n_done - b_done !== 1) begin bad++; $display("FAIL rnd%0d_done got=%0d want=1", it, n_done - b_done); end
      total++; if ((n_wmst - b_wmst) !== int'(wmb != 0) || (n_imst - b_imst) !== int'(imb != 0)) begin
        bad++; $display("FAIL rnd%0d_starts got=%0d/%0d want=%0d/%0d", it, n_wmst - b_wmst, n_imst - b_imst, wmb != 0, imb != 0); end
      total++; if ({ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout} !== {xw, xi, 1'b0}) begin
        bad++; $display("FAIL rnd%0d_flags wm=%0d im=%0d got=%b want=%b", it, wmb, imb,
                        {ctl.wm_mismatch, ctl.im_mismatch, ctl.timeout}, {xw, xi, 1'b0}); end
    end
  endtask

  initial begin
    areset = 1'b1;
    ctl.ap_start = 1'b0;
    ctl.wm_xfer_size_in_bytes = '0;
    ctl.im_xfer_size_in_bytes = '0;
    ctl.ctrl_timeout_cycles   = '0;
    ctl.wm_rd_done = 1'b0;
    ctl.wm_beat    = 1'b0;
    ctl.im_beat    = 1'b0;
    ctl.out_beat   = 1'b0;
    ctl.write_done = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_im_mismatch();
    test_timeout();
    test_early_write();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit reached at cycle %0d, bench did not complete", cyc);
    $fatal(1);
  end
endmodule

// File: doc/sdx_kernel_addwm_example_wm_ctrl.md
# sdx_kernel_addwm_example_wm_ctrl

Run sequencer for the watermark-embedding kernel datapath. It turns a single `ap_start` into an ordered two-phase run: watermark fetch first, then the image read, embed and write. It then returns `ap_done`/`ap_ready`/`ap_idle` to the control-register block. It also counts stream beats against the programmed transfer sizes and runs a per-phase stall watchdog, so that a hung or short transfer still terminates with a reportable error. It sits between the AXI-Lite control slave and the read-master / watermark-reader / write-master trio, all on one clock.

## Interface
- `C_XFER_SIZE_WIDTH`, 32, width of byte-count inputs
- `C_M_AXI_DATA_WIDTH`, 512, stream beat width; bytes per beat `LP_DW_BYTES` = C_M_AXI_DATA_WIDTH/8
- `C_TIMEOUT_WIDTH`, 24, watchdog counter width

Ports:
- `aclk` in 1: sole clock, rising edge
- `areset` in 1: synchronous, active-high reset
- `ap_start` in 1: run request, level
- `ap_idle` out 1: state==IDLE
- `ap_done` out 1: one-cycle run-complete pulse
- `ap_ready` out 1: identical to `ap_done`
- `wm_xfer_size_in_bytes` in C_XFER_SIZE_WIDTH: watermark bytes, sampled at start
- `im_xfer_size_in_bytes` in C_XFER_SIZE_WIDTH: image bytes, sampled at start
- `ctrl_timeout_cycles` in C_TIMEOUT_WIDTH: stall limit, sampled at start; 0 disables
- `wm_rd_start` out 1: one-cycle start to the watermark reader
- `wm_rd_done` in 1: watermark reader done pulse
- `wm_beat` in 1: watermark stream valid&ready
- `im_start` out 1: one-cycle start to the image read and write masters
- `im_beat` in 1: image-in stream valid&ready
- `out_beat` in 1: embedded-out stream valid&ready
- `write_done` in 1: write-master done pulse
- `wm_mismatch` out 1: sticky, watermark beat count ≠ expected
- `im_mismatch` out 1: sticky, image-in or out beat count ≠ expected
- `timeout` out 1: sticky, watchdog fired

## Operation
- States: IDLE, WM_START, WM_WAIT, IM_START, IM_WAIT, DONE. All outputs are decoded from registered state and flags (Moore).
- IDLE with `ap_start`=1:
  - Capture the sizes and the timeout limit.
  - Clear the three flags, the beat counters and the done latches.
  - Next state: WM_START if wm size ≠ 0; else IM_START if im size ≠ 0; else DONE.
- WM_START: `wm_rd_start`=1 for this cycle, then go to WM_WAIT.
- WM_WAIT: wait for the wm-done latch. Next state: IM_START if im size ≠ 0, else DONE.
- IM_START: `im_start`=1 for this cycle, then go to IM_WAIT.
- IM_WAIT: wait for the write-done latch, then go to DONE.
- DONE:
  - `ap_done`=`ap_ready`=1 for this cycle.
  - Compare counts and set the mismatch flags here, so they are visible from the cycle after DONE.
  - Next state: IDLE.
- Done latches: `wm_rd_done` and `write_done` are latched in any non-IDLE state. A pulse that arrives before its WAIT state is therefore honoured.
- Expected beats = ceil(bytes / LP_DW_BYTES), computed at capture as (bytes + LP_DW_BYTES−1) >> log2(LP_DW_BYTES), at C_XFER_SIZE_WIDTH+1 bits.
- Beat counters (C_XFER_SIZE_WIDTH bits):
  - Count in every non-IDLE state and saturate at all-ones.
  - `wm_cnt` counts `wm_beat`; `im_cnt` counts `im_beat`; `out_cnt` counts `out_beat`.
- Mismatch rules:
  - `wm_mismatch` = wm_cnt ≠ wm_exp.
  - `im_mismatch` = (im_cnt ≠ im_exp) | (out_cnt ≠ im_exp).
- Watchdog:
  - Active in WM_WAIT and IM_WAIT.
  - Cleared on entry to either state and on any beat input.
  - When the count equals `ctrl_timeout_cycles` (≠0): set `timeout` and go to DONE next cycle. No further start pulses are issued.
- Sticky flags hold until the next accepted `ap_start`.

## Timing
- Reset (`areset`=1 at an edge):
  - state=IDLE; `ap_idle`=1.
  - All other outputs 0; counters and latches 0.
  - Applies mid-run too: no `ap_done` is issued, and the aborted run is forgotten.
- `ap_start` sampled at edge N in IDLE:
  - `ap_idle`=0 and `wm_rd_start`=1 in cycle N+1.
  - WM_WAIT from N+2.
- `wm_rd_done` at edge M during WM_WAIT: latched at M, `im_start`=1 in cycle M+2.
- `write_done` at edge K during IM_WAIT: latched at K, `ap_done`=1 in cycle K+2, `ap_idle`=1 in K+3.
- Minimum run (both sizes 0): `ap_start` at N gives `ap_done` in N+1.
- `ap_start` held high through DONE is not re-accepted until IDLE. This gives at least one `ap_idle` cycle between runs.
- Simultaneous events:
  - A beat in the same cycle as a done pulse is counted.
  - A done pulse in the same cycle the watchdog fires: the timeout wins.
- Beats in DONE are counted but do not affect that run's flags.

## Test plan
- wm 1024 B, im 4096 B, timeout 0, 16 wm beats, `wm_rd_done` 5 cycles after `wm_rd_start`, 64 im and 64 out beats, `write_done` → `wm_rd_start` and `im_start` each pulse once; `im_start` 2 cycles after `wm_rd_done`; `ap_done`=`ap_ready` one cycle; all flags 0.
- Both sizes 0, `ap_start` at N → `ap_done` in N+1; no start pulses.
- im 100 B (expected 2 beats), drive 1 im beat and 2 out beats → `im_mismatch`=1 after DONE; `wm_mismatch`=0; flags clear on the next `ap_start`.
- timeout 10, no beats and no `wm_rd_done` after `wm_rd_start` → `timeout`=1; `ap_done` 11 cycles after entering WM_WAIT; `im_start` never asserted.
- `write_done` pulsed during WM_WAIT (early), then `wm_rd_done` → run completes without waiting for a second `write_done`.
- `areset` in IM_WAIT → next cycle `ap_idle`=1, no `ap_done`, flags 0; a fresh run then completes normally.
